// File: rtl/onchip_mem_pipelined.sv
// Single-port on-chip RAM behind a pipelined Avalon-MM slave, with a post-reset clear sequencer.
// Define ONCHIP_MEM_PARITY_EN to store and check one even-parity bit per byte.
module onchip_mem_pipelined #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DEPTH = 100000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic                    init_done,
    output logic                    parity_err
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e                  state;
    logic [ADDR_WIDTH-1:0]   clear_addr;
    logic                    init_done_q;

    logic                    clearing;
    logic                    in_range;
    logic                    wr_accept;
    logic                    rd_accept;
    logic                    ram_we;
    logic [IDX_WIDTH-1:0]    ram_idx;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [NUM_BYTES-1:0]    ram_be;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_q;

    logic                    rd_valid_a;
    logic                    rd_inrange_a;
    logic [DATA_WIDTH-1:0]   data_a;
    logic                    perr_a;

    assign init_done   = init_done_q;
    assign waitrequest = ~init_done_q | ~clken;
    assign clearing    = (state == StClear);
    assign in_range    = (32'(address) < DEPTH);

    // reset_n gates acceptance so nothing reaches the RAM on a reset edge
    assign wr_accept = reset_n & chipselect & write & ~waitrequest;
    assign rd_accept = reset_n & chipselect & read & ~write & ~waitrequest;

    always_comb begin
        ram_we    = 1'b0;
        ram_idx   = address[IDX_WIDTH-1:0];
        ram_wdata = writedata;
        ram_be    = byteenable;
        if (clearing) begin
            ram_we    = reset_n & clken;
            ram_idx   = clear_addr[IDX_WIDTH-1:0];
            ram_wdata = CLEAR_VALUE;
            ram_be    = '1;
        end else begin
            ram_we    = wr_accept & in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= (CLEAR_ON_RESET != 0) ? StClear : StReady;
            clear_addr  <= '0;
            init_done_q <= 1'b0;
        end else if (clken) begin
            case (state)
                StClear: begin
                    if (clear_addr == LAST_ADDR) begin
                        state       <= StReady;
                        init_done_q <= 1'b1;
                    end else begin
                        clear_addr  <= clear_addr + 1'b1;
                    end
                end
                StReady: init_done_q <= 1'b1;
                default: state <= StReady;
            endcase
        end
    end

    // Block RAM body: no reset, write and read share one address port
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (ram_be[b]) begin
                    mem[ram_idx][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end
        end
        if (rd_accept) begin
            ram_q <= mem[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_valid_a   <= 1'b0;
            rd_inrange_a <= 1'b0;
        end else if (clken) begin
            rd_valid_a <= rd_accept;
            if (rd_accept) begin
                rd_inrange_a <= in_range;
            end
        end
    end

    assign data_a = rd_inrange_a ? ram_q : '0;

`ifdef ONCHIP_MEM_PARITY_EN
    logic [NUM_BYTES-1:0] par_mem [DEPTH];
    logic [NUM_BYTES-1:0] par_q;
    logic [NUM_BYTES-1:0] par_wdata;
    logic [NUM_BYTES-1:0] par_calc;

    always_comb begin
        par_wdata = '0;
        par_calc  = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            par_wdata[b] = ^ram_wdata[b*8 +: 8];
            par_calc[b]  = ^ram_q[b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (ram_be[b]) begin
                    par_mem[ram_idx][b] <= par_wdata[b];
                end
            end
        end
        if (rd_accept) begin
            par_q <= par_mem[ram_idx];
        end
    end

    assign perr_a = rd_inrange_a & (par_calc != par_q);
`else
    assign perr_a = 1'b0;
`endif

    if (READ_LATENCY >= 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] rdata_q;
        logic                  rvalid_q;
        logic                  perr_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
                perr_q   <= 1'b0;
            end else if (clken) begin
                rvalid_q <= rd_valid_a;
                perr_q   <= rd_valid_a & perr_a;
                if (rd_valid_a) begin
                    rdata_q <= data_a;
                end
            end
        end

        assign readdata      = rdata_q;
        assign readdatavalid = rvalid_q & clken;
        assign parity_err    = perr_q & clken;
    end else begin : g_lat1
        // The RAM output register only loads on accepted reads, so data_a holds between pulses
        assign readdata      = data_a;
        assign readdatavalid = rd_valid_a & clken;
        assign parity_err    = rd_valid_a & perr_a & clken;
    end

endmodule

// File: tb/tb_onchip_mem_pipelined.sv
// Directed self-checking bench for onchip_mem_pipelined (DEPTH=16, READ_LATENCY=2).
module tb_onchip_mem_pipelined;

    localparam int AW = 5;
    localparam int RL = 2;
    localparam logic [31:0] CV = 32'hA5A5A5A5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clken;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          readdatavalid;
    logic          waitrequest;
    logic          init_done;
    logic          parity_err;

    int n_asserts = 0;
    int n_fail = 0;
    int cnt;

    logic [AW-1:0] rd_addr [16];
    logic [31:0]   rd_exp  [16];

    always #5 clk = ~clk;

    onchip_mem_pipelined #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (AW),
        .DEPTH          (16),
        .READ_LATENCY   (RL),
        .CLEAR_ON_RESET (1),
        .CLEAR_VALUE    (CV)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clken         (clken),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .address       (address),
        .byteenable    (byteenable),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .init_done     (init_done),
        .parity_err    (parity_err)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        byteenable = be;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    // Issue n back-to-back reads from rd_addr[] and check data, order, latency and gap-free valids
    task automatic burst(input int n, input string tag, input logic exp_perr);
        int got = 0;
        int first_c = -1;
        int last_c = -1;
        for (int c = 0; c < n + 6; c++) begin
            if (c < n) begin
                chipselect = 1'b1;
                read       = 1'b1;
                address    = rd_addr[c];
            end else begin
                chipselect = 1'b0;
                read       = 1'b0;
            end
            @(posedge clk); #1;
            if (readdatavalid === 1'b1) begin
                if (got < n) begin
                    check32({tag, "_data"}, readdata, rd_exp[got]);
                    check1({tag, "_perr"}, parity_err, exp_perr);
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
        end
        check32({tag, "_count"}, got, n);
        check32({tag, "_first"}, first_c, RL - 1);
        check32({tag, "_last"}, last_c, n + RL - 2);
        check32({tag, "_hold"}, readdata, rd_exp[n-1]);
    endtask

    initial begin
        reset_n    = 1'b0;
        clken      = 1'b1;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        byteenable = '0;
        writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_readdata", readdata, 32'h0);
        check1("rst_rdv", readdatavalid, 1'b0);
        check1("rst_wait", waitrequest, 1'b1);
        check1("rst_init", init_done, 1'b0);
        check1("rst_perr", parity_err, 1'b0);

        // Clear takes exactly DEPTH enabled cycles
        reset_n = 1'b1;
        cnt = 0;
        while (waitrequest === 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check32("clear_cycles", cnt, 16);
        check1("clear_init_done", init_done, 1'b1);

        for (int i = 0; i < 16; i++) begin
            rd_addr[i] = AW'(i);
            rd_exp[i]  = CV;
        end
        burst(16, "clear_read", 1'b0);

        // Partial byte write merges with the cleared pattern
        wr(5'd3, 32'h11223344, 4'b0101);
        rd_addr[0] = 5'd3;
        rd_exp[0]  = 32'hA522A544;
        burst(1, "byteen", 1'b0);

        for (int i = 0; i < 4; i++) wr(AW'(i), 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) begin
            rd_addr[i] = AW'(i);
            rd_exp[i]  = 32'(i);
        end
        burst(4, "b2b", 1'b0);

        // Three-cycle clken stall between acceptance and valid
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 5'd2;
        @(posedge clk); #1;
        chipselect = 1'b0;
        read       = 1'b0;
        clken      = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check1("stall_wait", waitrequest, 1'b1);
            check1("stall_rdv", readdatavalid, 1'b0);
            @(posedge clk); #1;
        end
        clken = 1'b1;
        #1;
        check1("stall_rdv_pre", readdatavalid, 1'b0);
        @(posedge clk); #1;
        check1("stall_rdv_late", readdatavalid, 1'b1);
        check32("stall_data", readdata, 32'h2);
        @(posedge clk); #1;
        check1("stall_rdv_single", readdatavalid, 1'b0);

        // Simultaneous read and write: write wins, read dropped
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b1;
        address    = 5'd5;
        writedata  = 32'h12345678;
        byteenable = 4'hF;
        @(posedge clk); #1;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check1("rw_no_rdv", readdatavalid, 1'b0);
            @(posedge clk); #1;
        end
        rd_addr[0] = 5'd5;
        rd_exp[0]  = 32'h12345678;
        burst(1, "rw_write", 1'b0);

        wr(5'd6, 32'hCAFEF00D, 4'hF);
        rd_addr[0] = 5'd6;
        rd_exp[0]  = 32'hCAFEF00D;
        burst(1, "wr_then_rd", 1'b0);

        wr(5'd7, 32'h0, 4'h0);
        rd_addr[0] = 5'd7;
        rd_exp[0]  = CV;
        burst(1, "be_zero", 1'b0);

        // Out-of-range read returns zero; out-of-range write does not alias
        rd_addr[0] = 5'd20;
        rd_exp[0]  = 32'h0;
        burst(1, "oor_read", 1'b0);
        wr(5'd20, 32'hFFFFFFFF, 4'hF);
        rd_addr[0] = 5'd4;
        rd_exp[0]  = CV;
        burst(1, "oor_write", 1'b0);

        // Reset with a read in flight: no valid, readdata cleared
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 5'd1;
        @(posedge clk); #1;
        chipselect = 1'b0;
        read       = 1'b0;
        reset_n    = 1'b0;
        @(posedge clk); #1;
        check1("midrst_rdv", readdatavalid, 1'b0);
        check32("midrst_readdata", readdata, 32'h0);
        check1("midrst_wait", waitrequest, 1'b1);
        check1("midrst_init", init_done, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            check1("midrst_lost", readdatavalid, 1'b0);
        end

        // Reset at clear_addr=7 with clken low: clear restarts, bus write ignored during clear
        reset_n = 1'b0;
        clken   = 1'b0;
        @(posedge clk); #1;
        reset_n    = 1'b1;
        clken      = 1'b1;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 5'd8;
        writedata  = 32'h0;
        byteenable = 4'hF;
        cnt = 0;
        while (init_done !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chipselect = 1'b0;
        write      = 1'b0;
        check32("restart_cycles", cnt, 16);
        rd_addr[0] = 5'd3;
        rd_exp[0]  = CV;
        rd_addr[1] = 5'd8;
        rd_exp[1]  = CV;
        burst(2, "restart_read", 1'b0);

`ifdef ONCHIP_MEM_PARITY_EN
        wr(5'd9, 32'h0F0F0F0F, 4'hF);
        dut.par_mem[9][0] = ~dut.par_mem[9][0];
        rd_addr[0] = 5'd9;
        rd_exp[0]  = 32'h0F0F0F0F;
        burst(1, "parity", 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/onchip_mem_pipelined.md
Name: onchip_mem_pipelined

Overview:
- Parametrised single-port on-chip RAM exposed as a pipelined Avalon-MM slave, replacing fixed-size single-cycle program/data memories in the Qsys-style system.
- Adds over the previous generation:
  - configurable width, depth and read latency (1 or 2)
  - readdatavalid/waitrequest handshake
  - hardware clear-to-value sequencer after reset
  - out-of-range address handling
- Sits between the system interconnect and a single inferred block RAM.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 17: word address width.
- DEPTH, 100000: number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1: cycles from accepted read to readdatavalid; legal values 1 or 2 (2 adds an output register).
- CLEAR_ON_RESET, 1: 1 = walk and write CLEAR_VALUE to every word after reset; 0 = contents untouched.
- CLEAR_VALUE, 0: DATA_WIDTH-bit fill pattern used by the clear sequencer.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- clken  in  1  clock enable; low freezes RAM, pipeline and FSM.
- chipselect  in  1  slave select.
- read  in  1  read request.
- write  in  1  write request.
- address  in  ADDR_WIDTH  word address.
- byteenable  in  DATA_WIDTH/8  per-byte write enable.
- writedata  in  DATA_WIDTH  write data.
- readdata  out  DATA_WIDTH  read data; valid when readdatavalid=1.
- readdatavalid  out  1  one-cycle pulse per accepted read.
- waitrequest  out  1  high = request not accepted this cycle.
- init_done  out  1  high once clear sequence complete (or immediately if CLEAR_ON_RESET=0).
- parity_err  out  1  read parity error pulse; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset, sampled with reset_n=0 at a clk edge, regardless of clken:
  - readdata=0, readdatavalid=0, parity_err=0, waitrequest=1, init_done=0.
  - Read pipeline flushed; clear_addr=0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else READY.
- FSM states: CLEAR and READY.
  - CLEAR: each clken=1 cycle writes CLEAR_VALUE (all bytes) to clear_addr, then clear_addr+1. After writing DEPTH-1, the FSM enters READY on the next edge; the clear therefore takes exactly DEPTH enabled cycles.
  - CLEAR: waitrequest=1; bus requests are ignored, not queued.
  - READY: init_done=1; waitrequest = ~clken (combinational).
- Accept rules:
  - Write accepted when chipselect & write & ~waitrequest; the RAM is written on that edge for bytes with byteenable=1.
  - Read accepted when chipselect & read & ~waitrequest.
- Read latency:
  - readdatavalid pulses exactly READ_LATENCY enabled cycles after acceptance.
  - Back-to-back reads give one valid per cycle, in order, with no bubbles.
  - readdata holds its last value between pulses.
- Simultaneous read & write in the same cycle: the write is performed; the read is dropped (no readdatavalid).
- Write then read of the same address on the next cycle returns the new data.
- byteenable=0 on write: accepted, memory unchanged.
- Out-of-range address (address >= DEPTH):
  - Write: accepted and discarded.
  - Read: accepted, returns all-zero readdata with a normal readdatavalid pulse.
- clken=0:
  - RAM, pipeline stages, FSM and clear_addr all hold.
  - readdatavalid is forced 0 for that cycle; a pending valid is presented on the next enabled cycle.
- Reset mid-operation: in-flight reads are lost (no readdatavalid is issued) and the clear restarts from address 0.

Optional Feature:
- Macro: ONCHIP_MEM_PARITY_EN.
- Defined:
  - RAM stores one even-parity bit per byte, computed from writedata (or CLEAR_VALUE during clear).
  - On read, parity is recomputed. parity_err pulses together with readdatavalid if any byte mismatches.
  - Out-of-range reads never flag.
- Undefined: no parity storage; parity_err is constant 0.

Test Plan:
- Use DEPTH=16, CLEAR_ON_RESET=1, CLEAR_VALUE=32'hA5A5A5A5. Release reset -> waitrequest=1 for exactly 16 clk cycles, then init_done=1; reading addr 0..15 returns 32'hA5A5A5A5 each.
- Use READ_LATENCY=2. Write 32'h11223344 to addr 3 with byteenable=4'b0101, then read addr 3 -> readdata=32'hA522A544 with readdatavalid exactly 2 cycles after acceptance.
- Issue 4 back-to-back reads of addr 0,1,2,3 (after writing 0..3) -> four consecutive readdatavalid pulses with data 0,1,2,3 in order.
- Drop clken low for 3 cycles between a read's acceptance and its valid -> waitrequest=1 during the stall, and readdatavalid is delayed by exactly 3 cycles with the data unchanged.
- Read addr 20 (>= DEPTH) -> readdata=0 with readdatavalid. Write to addr 20, then read addr 4 -> addr 4 unchanged.
- Pulse reset_n low during the clear at clear_addr=7 -> clear restarts at 0, and init_done rises 16 enabled cycles after reset release. With ONCHIP_MEM_PARITY_EN, forcing a stored parity bit flip makes the next read of that word assert parity_err=1 with readdatavalid.
